// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respErr;
    logic [31:0] memAddress;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [1:0]  memDQM;
    logic [31:0] memReadData;

    modport master (
        input  reqValid, reqWrite, reqOp, reqAddr, reqData, respReady, memReadData,
        output reqReady, respValid, respData, respErr,
        output memAddress, memWriteEnable, memWriteData, memDQM
    );

    modport slave (
        output reqValid, reqWrite, reqOp, reqAddr, reqData, respReady, memReadData,
        input  reqReady, respValid, respData, respErr,
        input  memAddress, memWriteEnable, memWriteData, memDQM
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with sub-word read-modify-write; LSU_PERF_CNT_EN adds event counters
module load_store_unit #(
    parameter int MEM_DEPTH = 1000
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.master  bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]        loadCount,
    output logic [31:0]        storeCount,
    output logic [31:0]        faultCount
`endif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] STORE_W = 3'd2;
    localparam logic [2:0] RMW_RD  = 3'd3;
    localparam logic [2:0] RMW_WR  = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] data_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic [1:0]  req_size;
    logic [31:0] req_index;
    logic        req_fault;
    logic [31:0] mem_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;
    logic [31:0] merged;

    assign mem_rdata = bus.memReadData;
    assign req_size  = bus.reqOp[1:0];
    assign req_index = {2'b00, bus.reqAddr[31:2]};

    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'b11)
            req_fault = 1'b1;
        if (req_size == SZ_H && bus.reqAddr[0])
            req_fault = 1'b1;
        if (req_size == SZ_W && bus.reqAddr[1:0] != 2'b00)
            req_fault = 1'b1;
        if (req_index >= 32'(MEM_DEPTH))
            req_fault = 1'b1;
    end

    always_comb begin
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            SZ_B:    load_value = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    load_value = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_value = mem_rdata;
        endcase
    end

    // The memory only writes full words, so splice the new lane into the word just read.
    always_comb begin
        merged = mem_rdata;
        if (op_q[1:0] == SZ_B)
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        else if (lane_q[1])
            merged[31:16] = data_q;
        else
            merged[15:0] = data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            data_q      <= 16'h0000;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.reqValid) begin
                        op_q        <= bus.reqOp;
                        lane_q      <= bus.reqAddr[1:0];
                        data_q      <= bus.reqData[15:0];
                        mem_addr_q  <= req_index;
                        resp_data_q <= 32'h0;
                        resp_err_q  <= req_fault;
                        if (req_fault) begin
                            state <= RESP;
                        end else if (!bus.reqWrite) begin
                            state <= LOAD;
                        end else if (req_size == SZ_W) begin
                            mem_wdata_q <= bus.reqData;
                            state       <= STORE_W;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_data_q <= load_value;
                    state       <= RESP;
                end
                STORE_W: state <= RESP;
                RMW_RD: begin
                    mem_wdata_q <= merged;
                    state       <= RMW_WR;
                end
                RMW_WR: state <= RESP;
                RESP: begin
                    if (bus.respReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reqReady       = (state == IDLE);
    assign bus.respValid      = (state == RESP);
    assign bus.respData       = resp_data_q;
    assign bus.respErr        = resp_err_q;
    assign bus.memAddress     = mem_addr_q;
    assign bus.memWriteEnable = (state == STORE_W) || (state == RMW_WR);
    assign bus.memWriteData   = mem_wdata_q;
    assign bus.memDQM         = SZ_W;

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadCount  <= 32'h0;
            storeCount <= 32'h0;
            faultCount <= 32'h0;
        end else begin
            if (state == LOAD)
                loadCount <= loadCount + 32'd1;
            if (state == STORE_W || state == RMW_WR)
                storeCount <= storeCount + 32'd1;
            if (state == IDLE && bus.reqValid && req_fault)
                faultCount <= faultCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit with a reference memory model
module tb_load_store_unit;
    localparam int MEM_DEPTH = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();

`ifdef LSU_PERF_CNT_EN
    logic [31:0] loadCount, storeCount, faultCount;
`endif

    load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LSU_PERF_CNT_EN
        ,
        .loadCount(loadCount),
        .storeCount(storeCount),
        .faultCount(faultCount)
`endif
    );

    // attached word memory
    logic [31:0] tb_mem [0:MEM_DEPTH-1];
    assign bus.memReadData = (bus.memAddress < 32'(MEM_DEPTH)) ? tb_mem[bus.memAddress] : 32'h0;
    always @(posedge clk)
        if (bus.memWriteEnable && bus.memAddress < 32'(MEM_DEPTH))
            tb_mem[bus.memAddress] <= bus.memWriteData;

    logic [31:0] ref_mem [0:MEM_DEPTH-1];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          check_en = 1'b0;
    bit          pending = 1'b0;
    int          exp_resp_cycle = 0;
    int          exp_we_cycle = -1;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_widx = 32'h0;
    logic [31:0] exp_wword = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome of one request, from the architectural rules only.
    function automatic void model(input bit w, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] data, output bit err, output logic [31:0] rdata,
                                  output int lat, output bit wr, output logic [31:0] widx,
                                  output logic [31:0] wword);
        logic [1:0]  size;
        logic [63:0] mask, val;
        int          sh;
        size  = op[1:0];
        widx  = addr >> 2;
        sh    = int'(addr[1:0]) * 8;
        err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) || (widx >= 32'(MEM_DEPTH));
        rdata = 32'h0;
        wr    = 1'b0;
        wword = 32'h0;
        lat   = 1;
        if (err) return;
        mask = (64'd1 << (8 << size)) - 64'd1;
        if (!w) begin
            val = ({32'h0, ref_mem[widx]} >> sh) & mask;
            if (!op[2] && val[(8 << size) - 1]) val = val | ~mask;
            rdata = val[31:0];
            lat   = 2;
        end else begin
            val   = ({32'h0, ref_mem[widx]} & ~(mask << sh)) | (({32'h0, data}) & mask) << sh;
            wword = val[31:0];
            wr    = 1'b1;
            lat   = (size == 2'b10) ? 2 : 3;
        end
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            bit exp_valid, exp_we;
            exp_valid = pending && (cyc >= exp_resp_cycle);
            exp_we    = pending && (cyc == exp_we_cycle);
            chk("reqReady", {31'b0, bus.reqReady}, {31'b0, !pending});
            chk("respValid", {31'b0, bus.respValid}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk("respData", bus.respData, exp_rdata);
                chk("respErr", {31'b0, bus.respErr}, {31'b0, exp_err});
            end
            chk("memWriteEnable", {31'b0, bus.memWriteEnable}, {31'b0, exp_we});
            if (exp_we) begin
                chk("memAddress", bus.memAddress, exp_widx);
                chk("memWriteData", bus.memWriteData, exp_wword);
                chk("memDQM", {30'b0, bus.memDQM}, 32'd2);
            end
        end
    end

    task automatic do_req(input bit w, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int hold, input bit keep,
                          output logic [31:0] got_d, output logic got_e);
        int n;
        int lat;
        bit wr;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqOp    = op;
        bus.reqAddr  = addr;
        bus.reqData  = data;
        n = 0;
        while (!bus.reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'b0, n >= 50}, 32'd0);
        @(posedge clk);
        #1;
        model(w, op, addr, data, exp_err, exp_rdata, lat, wr, exp_widx, exp_wword);
        if (wr) ref_mem[exp_widx] = exp_wword;
        exp_resp_cycle = cyc + lat - 1;
        exp_we_cycle   = wr ? exp_resp_cycle - 1 : -1;
        pending        = 1'b1;
        if (!keep) bus.reqValid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc < exp_resp_cycle && n < 20);
        repeat (hold) @(negedge clk);
        got_d = bus.respData;
        got_e = bus.respErr;
        bus.respReady = 1'b1;
        @(posedge clk);
        #1;
        pending       = 1'b0;
        bus.respReady = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_reqReady"}, {31'b0, bus.reqReady}, 32'd1);
        chk({tag, "_respValid"}, {31'b0, bus.respValid}, 32'd0);
        chk({tag, "_respData"}, bus.respData, 32'h0);
        chk({tag, "_respErr"}, {31'b0, bus.respErr}, 32'd0);
        chk({tag, "_memAddress"}, bus.memAddress, 32'h0);
        chk({tag, "_memWriteEnable"}, {31'b0, bus.memWriteEnable}, 32'd0);
        chk({tag, "_memWriteData"}, bus.memWriteData, 32'h0);
        chk({tag, "_memDQM"}, {30'b0, bus.memDQM}, 32'd2);
    endtask

    task automatic pin_model(input string name, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] exp);
        bit e, wr;
        logic [31:0] d, wi, ww;
        int lat;
        model(1'b0, op, addr, 32'h0, e, d, lat, wr, wi, ww);
        chk(name, d, exp);
    endtask

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_X  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    initial begin
        logic [31:0] d;
        logic        e;
        int          n;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqOp = 3'b000;
        bus.reqAddr = 32'h0; bus.reqData = 32'h0; bus.respReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_en = 1'b1;

        do_req(1'b1, OP_W, 32'h10, 32'hDEADBEEF, 0, 1'b0, d, e);
        chk("sw_resp", d, 32'h0);
        do_req(1'b0, OP_W, 32'h10, 32'h0, 0, 1'b0, d, e);
        chk("lw_10", d, 32'hDEADBEEF);
        chk("lw_10_err", {31'b0, e}, 32'd0);

        do_req(1'b1, OP_B, 32'h13, 32'h55, 0, 1'b0, d, e);
        do_req(1'b0, OP_W, 32'h10, 32'h0, 0, 1'b0, d, e);
        chk("lw_after_sb", d, 32'h55ADBEEF);
        do_req(1'b0, OP_B, 32'h13, 32'h0, 0, 1'b0, d, e);
        chk("lb_13", d, 32'h00000055);
        do_req(1'b0, OP_B, 32'h12, 32'h0, 0, 1'b0, d, e);
        chk("lb_12", d, 32'hFFFFFFAD);
        do_req(1'b0, OP_BU, 32'h12, 32'h0, 0, 1'b0, d, e);
        chk("lbu_12", d, 32'h000000AD);

        do_req(1'b1, OP_H, 32'h12, 32'h8001, 0, 1'b0, d, e);
        do_req(1'b0, OP_H, 32'h12, 32'h0, 0, 1'b0, d, e);
        chk("lh_12", d, 32'hFFFF8001);
        do_req(1'b0, OP_HU, 32'h12, 32'h0, 0, 1'b0, d, e);
        chk("lhu_12", d, 32'h00008001);
        do_req(1'b0, OP_W, 32'h10, 32'h0, 0, 1'b0, d, e);
        chk("lw_after_sh", d, 32'h8001BEEF);
        pin_model("model_lb_13", OP_B, 32'h13, 32'hFFFFFF80);
        pin_model("model_lhu_10", OP_HU, 32'h10, 32'h0000BEEF);
        pin_model("model_lb_10", OP_B, 32'h10, 32'hFFFFFFEF);

        do_req(1'b0, OP_W, 32'h11, 32'h0, 0, 1'b0, d, e);
        chk("fault_lw_11", {31'b0, e}, 32'd1);
        do_req(1'b1, OP_H, 32'h13, 32'h1234, 0, 1'b0, d, e);
        chk("fault_sh_13", {31'b0, e}, 32'd1);
        do_req(1'b0, OP_X, 32'h10, 32'h0, 0, 1'b0, d, e);
        chk("fault_size11", {31'b0, e}, 32'd1);
        chk("fault_size11_data", d, 32'h0);
        do_req(1'b1, OP_W, 32'(4 * MEM_DEPTH), 32'hCAFEF00D, 0, 1'b0, d, e);
        chk("fault_sw_depth", {31'b0, e}, 32'd1);

        do_req(1'b1, OP_W, 32'(4 * (MEM_DEPTH - 1)), 32'hA5A5_0001, 0, 1'b0, d, e);
        chk("sw_last_err", {31'b0, e}, 32'd0);
        do_req(1'b0, OP_W, 32'(4 * (MEM_DEPTH - 1)), 32'h0, 0, 1'b0, d, e);
        chk("lw_last", d, 32'hA5A50001);

        do_req(1'b0, OP_W, 32'h10, 32'h0, 5, 1'b1, d, e);
        chk("bp_first", d, 32'h8001BEEF);
        do_req(1'b0, OP_W, 32'h10, 32'h0, 0, 1'b0, d, e);
        chk("bp_second", d, 32'h8001BEEF);

        do_req(1'b1, OP_W, 32'h20, 32'h12345678, 0, 1'b0, d, e);
        @(negedge clk);
        bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqOp = OP_B;
        bus.reqAddr = 32'h20; bus.reqData = 32'hAA;
        n = 0;
        while (!bus.reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept_timeout", {31'b0, n >= 50}, 32'd0);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        bus.reqValid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        do_req(1'b0, OP_W, 32'h20, 32'h0, 0, 1'b0, d, e);
        chk("word8_unchanged", d, 32'h12345678);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
